// File: rtl/rvv_vcfg_unit.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl and owns the vtype/vl CSRs.
// A vtype change waits for the vector backend to drain; vl-only changes commit at once.
module rvv_vcfg_unit #(
   parameter int VLEN = 128,
   parameter int ELEN = 64,
   parameter int XLEN = 32,
   parameter int VlW  = $clog2(VLEN) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [31:0]     req_insn_i,
   input  logic [XLEN-1:0] req_rs1_i,
   input  logic [XLEN-1:0] req_rs2_i,
   input  logic            backend_idle_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [4:0]      resp_rd_o,
   output logic [XLEN-1:0] resp_data_o,
   output logic            resp_err_o,
   output logic [7:0]      vtype_o,
   output logic [VlW-1:0]  vl_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [7:0] ELEN_B = 8'(ELEN);

   logic [1:0]      state;
   logic [7:0]      pend_vtype;
   logic [VlW-1:0]  pend_vl;
   logic [4:0]      pend_rd;
   logic            pend_err;

   logic            is_opcfg;
   logic            is_vsetvli;
   logic            is_vsetivli;
   logic            is_vsetvl;
   logic            is_cfg;
   logic [4:0]      rd_idx;
   logic [4:0]      rs1_idx;
   logic [XLEN-1:0] raw_vtype;
   logic [2:0]      vlmul;
   logic [2:0]      vsew;
   logic [7:0]      sew_bits;
   logic            frac_ill;
   logic [VlW-1:0]  new_vlmax;
   logic [VlW-1:0]  cur_vlmax;
   logic [XLEN-1:0] avl;
   logic            keep_vl;
   logic            vill;
   logic [VlW-1:0]  vl_calc;
   logic [7:0]      next_vtype;
   logic [VlW-1:0]  next_vl;
   logic            commit;
   logic            unused_vtype_msb;

   // VLMAX = (VLEN / SEW) * LMUL, built from shifts since every factor is a power of two
   function automatic logic [VlW-1:0] calc_vlmax(input logic [2:0] sew, input logic [2:0] lmul);
      logic [VlW-1:0] base;
      base = VlW'(VLEN >> (3 + int'(sew)));
      case (lmul)
         3'b000:  calc_vlmax = base;
         3'b001:  calc_vlmax = base << 1;
         3'b010:  calc_vlmax = base << 2;
         3'b011:  calc_vlmax = base << 3;
         3'b101:  calc_vlmax = base >> 3;
         3'b110:  calc_vlmax = base >> 2;
         3'b111:  calc_vlmax = base >> 1;
         default: calc_vlmax = '0;
      endcase
   endfunction

   assign is_opcfg    = (req_insn_i[6:0] == 7'b1010111) && (req_insn_i[14:12] == 3'b111);
   assign is_vsetvli  = is_opcfg && !req_insn_i[31];
   assign is_vsetivli = is_opcfg && (req_insn_i[31:30] == 2'b11);
   assign is_vsetvl   = is_opcfg && (req_insn_i[31:25] == 7'b1000000);
   assign is_cfg      = is_vsetvli || is_vsetivli || is_vsetvl;
   assign rd_idx      = req_insn_i[11:7];
   assign rs1_idx     = req_insn_i[19:15];

   always_comb begin
      raw_vtype = '0;
      if (is_vsetvl) begin
         raw_vtype = req_rs2_i;
      end else if (is_vsetivli) begin
         raw_vtype[9:0] = req_insn_i[29:20];
      end else begin
         raw_vtype[10:0] = req_insn_i[30:20];
      end
   end

   assign vlmul            = raw_vtype[2:0];
   assign vsew             = raw_vtype[5:3];
   assign sew_bits         = 8'd8 << vsew[1:0];
   assign unused_vtype_msb = raw_vtype[XLEN-1];

   always_comb begin
      frac_ill = 1'b0;
      case (vlmul)
         3'b101:  frac_ill = sew_bits > (ELEN_B >> 3);
         3'b110:  frac_ill = sew_bits > (ELEN_B >> 2);
         3'b111:  frac_ill = sew_bits > (ELEN_B >> 1);
         default: frac_ill = 1'b0;
      endcase
   end

   // An illegal current vtype has no meaningful VLMAX, so keep-vl against it always mismatches
   assign new_vlmax = calc_vlmax(vsew, vlmul);
   assign cur_vlmax = vtype_o[7] ? '0 : calc_vlmax({1'b0, vtype_o[4:3]}, vtype_o[2:0]);

   always_comb begin
      avl     = '0;
      keep_vl = 1'b0;
      if (is_vsetivli) begin
         avl = XLEN'(rs1_idx);
      end else if (rs1_idx != 5'd0) begin
         avl = req_rs1_i;
      end else if (rd_idx != 5'd0) begin
         avl = '1;
      end else begin
         avl     = XLEN'(vl_o);
         keep_vl = 1'b1;
      end
   end

   assign vill = (vlmul == 3'b100) || vsew[2] || (sew_bits > ELEN_B) || frac_ill ||
                 (|raw_vtype[XLEN-2:8]) || (new_vlmax == '0) ||
                 (keep_vl && (new_vlmax != cur_vlmax));

   assign vl_calc    = (avl < XLEN'(new_vlmax)) ? VlW'(avl) : new_vlmax;
   assign next_vtype = vill ? 8'h80 : {1'b0, raw_vtype[7], raw_vtype[6], vsew[1:0], vlmul};
   assign next_vl    = vill ? '0 : vl_calc;

   // Errors touch no CSR, and an unchanged vtype cannot disturb in-flight vector work
   assign commit = pend_err || backend_idle_i || (pend_vtype == vtype_o);

   assign req_ready_o  = (state == ST_IDLE);
   assign resp_valid_o = (state == ST_RESP);

   // Request/commit/response sequencing plus the architectural CSRs and response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         pend_vtype  <= 8'h80;
         pend_vl     <= '0;
         pend_rd     <= '0;
         pend_err    <= 1'b0;
         vtype_o     <= 8'h80;
         vl_o        <= '0;
         resp_rd_o   <= '0;
         resp_data_o <= '0;
         resp_err_o  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  pend_rd    <= rd_idx;
                  pend_err   <= !is_cfg;
                  pend_vtype <= is_cfg ? next_vtype : vtype_o;
                  pend_vl    <= is_cfg ? next_vl : vl_o;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (commit) begin
                  if (!pend_err) begin
                     vtype_o <= pend_vtype;
                     vl_o    <= pend_vl;
                  end
                  resp_rd_o   <= pend_rd;
                  resp_err_o  <= pend_err;
                  resp_data_o <= pend_err ? '0 : XLEN'(pend_vl);
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready_i) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rvv_vcfg_unit.sv
// Self-checking bench for rvv_vcfg_unit: directed vector table, stall/handshake/reset
// sequences, then random requests checked against an arithmetic model of the CSR rules.
`timescale 1ns/1ps
module tb_rvv_vcfg_unit;

   localparam int VLEN = 128;
   localparam int ELEN = 64;
   localparam int XLEN = 32;
   localparam int VlW  = $clog2(VLEN) + 1;

   typedef struct packed {
      logic [7:0] vtype;
      logic [7:0] vl;
      logic       err;
      logic [4:0] rd;
   } res_t;

   typedef struct {
      string       name;
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
      res_t        exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            reqValid = 1'b0;
   logic            reqReady;
   logic [31:0]     reqInsn = '0;
   logic [XLEN-1:0] reqRs1 = '0;
   logic [XLEN-1:0] reqRs2 = '0;
   logic            backendIdle = 1'b1;
   logic            respValid;
   logic            respReady = 1'b0;
   logic [4:0]      respRd;
   logic [XLEN-1:0] respData;
   logic            respErr;
   logic [7:0]      vtype;
   logic [VlW-1:0]  vl;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] modelVtype = 8'h80;
   int         modelVl = 0;
   vec_t       vecs[$];

   rvv_vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (reqValid),
      .req_ready_o    (reqReady),
      .req_insn_i     (reqInsn),
      .req_rs1_i      (reqRs1),
      .req_rs2_i      (reqRs2),
      .backend_idle_i (backendIdle),
      .resp_valid_o   (respValid),
      .resp_ready_i   (respReady),
      .resp_rd_o      (respRd),
      .resp_data_o    (respData),
      .resp_err_o     (respErr),
      .vtype_o        (vtype),
      .vl_o           (vl)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] encVli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
      return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
   endfunction

   function automatic logic [31:0] encIvli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
      return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
   endfunction

   function automatic logic [31:0] encVl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
   endfunction

   function automatic res_t mk(input logic [7:0] vt, input int vlv, input bit err, input int rd);
      res_t r;
      r.vtype = vt;
      r.vl    = 8'(vlv);
      r.err   = err;
      r.rd    = 5'(rd);
      return r;
   endfunction

   function automatic int lmulNum(input logic [2:0] l);
      case (l)
         3'b001:  return 2;
         3'b010:  return 4;
         3'b011:  return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int lmulDen(input logic [2:0] l);
      case (l)
         3'b101:  return 8;
         3'b110:  return 4;
         3'b111:  return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int vlmaxOf(input logic [2:0] sewCode, input logic [2:0] lmul);
      int sew;
      sew = 8 << sewCode;
      return (VLEN * lmulNum(lmul)) / (sew * lmulDen(lmul));
   endfunction

   // Expected CSRs and response for one request, given the model's current CSRs
   function automatic res_t modelConfig(input logic [31:0] insn, input logic [31:0] rs1v,
                                        input logic [31:0] rs2v, input logic [7:0] curVt, input int curVl);
      res_t        r;
      logic [31:0] vt;
      longint      avl;
      int          sew, vlmax, curVlmax;
      bit          legal, keep;
      r = mk(curVt, curVl, 1'b0, int'(insn[11:7]));
      vt = '0;
      keep = 1'b0;
      if (insn[6:0] != 7'h57 || insn[14:12] != 3'b111) begin
         r.err = 1'b1;
         return r;
      end
      if (!insn[31]) vt = {21'b0, insn[30:20]};
      else if (insn[31:30] == 2'b11) vt = {22'b0, insn[29:20]};
      else if (insn[31:25] == 7'b1000000) vt = rs2v;
      else begin
         r.err = 1'b1;
         return r;
      end
      sew = 8 << vt[5:3];
      legal = (vt[2:0] != 3'b100) && (vt[5:3] < 3'd4) && (sew <= ELEN) &&
              (sew * lmulDen(vt[2:0]) <= ELEN) && (vt[30:8] == 23'd0);
      vlmax = vlmaxOf(vt[5:3], vt[2:0]);
      curVlmax = curVt[7] ? 0 : vlmaxOf({1'b0, curVt[4:3]}, curVt[2:0]);
      if (insn[31:30] == 2'b11) avl = longint'(insn[19:15]);
      else if (insn[19:15] != 5'd0) avl = longint'(rs1v);
      else if (insn[11:7] != 5'd0) avl = 64'hFFFF_FFFF;
      else begin
         avl = longint'(curVl);
         keep = 1'b1;
      end
      if (keep && vlmax != curVlmax) legal = 1'b0;
      if (vlmax == 0) legal = 1'b0;
      r.vtype = legal ? {1'b0, vt[7], vt[6], vt[4:3], vt[2:0]} : 8'h80;
      r.vl    = legal ? 8'((avl < longint'(vlmax)) ? avl : longint'(vlmax)) : 8'd0;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting clock edge
   task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1v, input logic [31:0] rs2v);
      checkOutput("req_ready_idle", 32'(reqReady), 32'd1);
      reqValid = 1'b1;
      reqInsn  = insn;
      reqRs1   = rs1v;
      reqRs2   = rs2v;
      @(negedge clk);
      reqValid = 1'b0;
   endtask

   task automatic runTxn(input string name, input logic [31:0] insn, input logic [31:0] rs1v,
                         input logic [31:0] rs2v, input int stall, input int respDelay, input res_t exp);
      int          waitCnt;
      int          expWait;
      logic [31:0] expData;
      expWait = (!exp.err && exp.vtype != modelVtype) ? stall + 1 : 1;
      expData = exp.err ? 32'd0 : 32'(exp.vl);
      applyStimulus(insn, rs1v, rs2v);
      waitCnt = 0;
      while (!respValid && waitCnt < 40) begin
         if (waitCnt > 0) begin
            checkOutput({name, ".hold_vtype"}, 32'(vtype), 32'(modelVtype));
            checkOutput({name, ".hold_ready"}, 32'(reqReady), 32'd0);
         end
         backendIdle = (waitCnt >= stall);
         @(negedge clk);
         waitCnt++;
      end
      checkOutput({name, ".latency"}, 32'(waitCnt), 32'(expWait));
      checkOutput({name, ".data"}, respData, expData);
      checkOutput({name, ".err"}, 32'(respErr), 32'(exp.err));
      checkOutput({name, ".rd"}, 32'(respRd), 32'(exp.rd));
      checkOutput({name, ".vtype"}, 32'(vtype), 32'(exp.vtype));
      checkOutput({name, ".vl"}, 32'(vl), 32'(exp.vl));
      for (int d = 0; d < respDelay; d++) begin
         @(negedge clk);
         checkOutput({name, ".stall_valid"}, 32'(respValid), 32'd1);
         checkOutput({name, ".stall_data"}, respData, expData);
         checkOutput({name, ".stall_rd"}, 32'(respRd), 32'(exp.rd));
         checkOutput({name, ".stall_ready"}, 32'(reqReady), 32'd0);
      end
      respReady = 1'b1;
      @(negedge clk);
      respReady   = 1'b0;
      backendIdle = 1'b1;
      checkOutput({name, ".resp_drop"}, 32'(respValid), 32'd0);
      if (!exp.err) begin
         modelVtype = exp.vtype;
         modelVl    = int'(exp.vl);
      end
   endtask

   initial begin
      res_t        exp;
      logic [31:0] insn, rs1v, rs2v;
      logic [7:0]  zimm;
      int          kind;

      vecs.push_back('{"vli_e32m1",      encVli(3, 5, 11'h010),  32'd100,        32'd0,     mk(8'h10, 4, 0, 3)});
      vecs.push_back('{"ivli_e8m8",      encIvli(1, 3, 10'h003), 32'd0,          32'd0,     mk(8'h03, 3, 0, 1)});
      vecs.push_back('{"vli_x0_e16mf2",  encVli(2, 0, 11'h00F),  32'd0,          32'd0,     mk(8'h0F, 4, 0, 2)});
      vecs.push_back('{"vli_e64mf8",     encVli(4, 6, 11'h01D),  32'd10,         32'd0,     mk(8'h80, 0, 0, 4)});
      vecs.push_back('{"vli_e32m1_b",    encVli(5, 7, 11'h010),  32'd2,          32'd0,     mk(8'h10, 2, 0, 5)});
      vecs.push_back('{"keep_mismatch",  encVli(0, 0, 11'h011),  32'd0,          32'd0,     mk(8'h80, 0, 0, 0)});
      vecs.push_back('{"vl_ma_ta",       encVl(8, 9, 10),        32'd1000,       32'hD8,    mk(8'h78, 2, 0, 8)});
      vecs.push_back('{"vl_hibit",       encVl(9, 1, 2),         32'd5,          32'h110,   mk(8'h80, 0, 0, 9)});
      vecs.push_back('{"nonconfig",      32'h002081B3,           32'd7,          32'd7,     mk(8'h80, 0, 1, 3)});
      vecs.push_back('{"vli_full_avl",   encVli(1, 2, 11'h000),  32'h8000_0000,  32'd0,     mk(8'h00, 16, 0, 1)});
      vecs.push_back('{"keep_match",     encVli(0, 0, 11'h009),  32'd0,          32'd0,     mk(8'h09, 16, 0, 0)});
      vecs.push_back('{"ivli_31",        encIvli(2, 31, 10'h000), 32'd0,         32'd0,     mk(8'h00, 16, 0, 2)});
      vecs.push_back('{"lmul_rsvd",      encVli(1, 2, 11'h004),  32'd5,          32'd0,     mk(8'h80, 0, 0, 1)});
      vecs.push_back('{"e8mf8",          encVli(1, 2, 11'h005),  32'd5,          32'd0,     mk(8'h05, 2, 0, 1)});
      vecs.push_back('{"sew_rsvd",       encVli(1, 2, 11'h020),  32'd5,          32'd0,     mk(8'h80, 0, 0, 1)});
      vecs.push_back('{"e16mf8",         encVli(1, 2, 11'h00D),  32'd5,          32'd0,     mk(8'h80, 0, 0, 1)});
      vecs.push_back('{"e32mf2",         encVli(1, 2, 11'h017),  32'd1,          32'd0,     mk(8'h17, 1, 0, 1)});
      vecs.push_back('{"vl_rs1x0",       encVl(3, 0, 4),         32'd0,          32'h0A,    mk(8'h0A, 32, 0, 3)});

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset.vtype", 32'(vtype), 32'h80);
      checkOutput("reset.vl", 32'(vl), 32'd0);
      checkOutput("reset.ready", 32'(reqReady), 32'd1);
      checkOutput("reset.resp_valid", 32'(respValid), 32'd0);
      checkOutput("reset.resp_data", respData, 32'd0);

      foreach (vecs[i]) runTxn(vecs[i].name, vecs[i].insn, vecs[i].rs1, vecs[i].rs2, 0, 0, vecs[i].exp);

      // vtype change held off by a busy backend, then a vl-only change that needs no drain
      insn = encVli(1, 2, 11'h010);
      runTxn("stall_change", insn, 32'd100, 32'd0, 5, 0, modelConfig(insn, 32'd100, 32'd0, modelVtype, modelVl));
      runTxn("vl_only_busy", insn, 32'd3, 32'd0, 10, 0, modelConfig(insn, 32'd3, 32'd0, modelVtype, modelVl));
      insn = encIvli(4, 7, 10'h010);
      runTxn("resp_hold", insn, 32'd0, 32'd0, 0, 3, modelConfig(insn, 32'd0, 32'd0, modelVtype, modelVl));

      // Reset while a vtype change sits in WAIT must drop it
      backendIdle = 1'b0;
      applyStimulus(encVli(1, 2, 11'h000), 32'd5, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_wait.vtype", 32'(vtype), 32'h80);
      checkOutput("rst_wait.vl", 32'(vl), 32'd0);
      checkOutput("rst_wait.ready", 32'(reqReady), 32'd1);
      rst = 1'b0;
      backendIdle = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_wait.no_resp", 32'(respValid), 32'd0);
      checkOutput("rst_wait.vtype_after", 32'(vtype), 32'h80);
      modelVtype = 8'h80;
      modelVl    = 0;

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 5));
         zimm = {1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7))};
         rs1v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         rs2v = $urandom;
         case (kind)
            0, 1: insn = encVli(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                {($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000, zimm});
            2: insn = encIvli(5'($urandom_range(0, 3)), 5'($urandom),
                              {($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00, zimm});
            3: begin
               rs2v = {($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'd0, zimm};
               insn = encVl(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
            end
            4: insn = encVli(5'd0, 5'd0, {3'b000, zimm});
            default: insn = $urandom;
         endcase
         exp = modelConfig(insn, rs1v, rs2v, modelVtype, modelVl);
         runTxn($sformatf("rand%0d", n), insn, rs1v, rs2v, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
